syncgen: RTL and testbench
==========================

Name: syncgen

Overview:
- Composite video timing generator and sync inserter: the transmit-side counterpart of the sync detector.
- Produces a 6-bit CVBS sample stream with PAL-style line and frame timing:
  - negative hsync tips;
  - back porch;
  - active video built from upstream luma;
  - broad vsync pulses that the detector recognises as low periods longer than 3x hsync.
- Also exports the digital hsync, vsync, porch and pixel-request strobes.
- Sits between the pixel source (framebuffer reader or test pattern) and the DAC or loopback into the detector.

Parameters:
- LINE_TICKS, 1536, ce ticks per line (64 us at 24 MHz).
- HSYNC_TICKS, 113, ce ticks of the hsync tip (4.7 us).
- BACKPORCH_TICKS, 137, ce ticks of the back porch (5.7 us).
- ACTIVE_TICKS, 1248, ce ticks of active video per line.
- LINES, 312, lines per frame.
- VSYNC_LINES, 3, broad-pulse lines at the start of the frame.
- VBLANK_LINES, 25, lines from frame start with no active video (includes VSYNC_LINES).
- SYNC_LEVEL, 0, CVBS code for the sync tip.
- BLANK_LEVEL, 12, CVBS code for blanking/black.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  sample-rate clock enable.
- luma  in  6  upstream pixel value, 0 = black; sampled on a ce tick while pix_rd=1.
- cvbs  out  6  composite sample, registered.
- hsync  out  1  active-low line sync, registered.
- vsync  out  1  active-low frame sync, registered.
- porch  out  1  high during back porch of normal lines, registered.
- pix_rd  out  1  high on the ticks where luma is consumed; decoded from counter registers.
- frame_start  out  1  one-clk pulse on the ce tick where vcnt wraps to 0, registered.
- line  out  9  current vcnt.

Behaviour:
- Internal counters:
  - hcnt 0..LINE_TICKS-1; vcnt 0..LINES-1.
  - Both advance only when ce=1.
  - hcnt wraps to 0 and increments vcnt; vcnt wraps LINES-1 -> 0.
  - ce=0: all state and outputs hold. frame_start is the exception: it clears on the next clk.
- Reset (async, any time including mid-line):
  - hcnt=0, vcnt=0.
  - cvbs=BLANK_LEVEL, hsync=1, vsync=1, porch=0, frame_start=0.
  - pix_rd=0 while reset is asserted.
- Latency and timing: on each ce tick the output registers take the region decode of the current (hcnt, vcnt), then the counters advance. Outputs therefore lag counters by one ce tick. cvbs reflects the luma sampled on the same tick.
- Normal line (vcnt >= VSYNC_LINES):
  - hcnt < HSYNC_TICKS: cvbs=SYNC_LEVEL, hsync=0.
  - HSYNC_TICKS <= hcnt < HSYNC_TICKS+BACKPORCH_TICKS: cvbs=BLANK_LEVEL, porch=1.
  - Active window A = [HSYNC_TICKS+BACKPORCH_TICKS, HSYNC_TICKS+BACKPORCH_TICKS+ACTIVE_TICKS):
    - if vcnt >= VBLANK_LINES: pix_rd=1 and cvbs = min(BLANK_LEVEL+luma, 63). The sum is computed 7 bits wide and saturated.
    - otherwise cvbs=BLANK_LEVEL and pix_rd=0.
  - Remainder of the line: cvbs=BLANK_LEVEL.
- Broad-pulse line (vcnt < VSYNC_LINES):
  - hcnt < LINE_TICKS-HSYNC_TICKS: cvbs=SYNC_LEVEL, hsync=0.
  - else cvbs=BLANK_LEVEL, hsync=1.
  - vsync=0 for the whole line; porch=0; pix_rd=0.
- frame_start: asserted with the output update of hcnt=0, vcnt=0.
- Parameter legality (elaboration assertion): HSYNC_TICKS+BACKPORCH_TICKS+ACTIVE_TICKS <= LINE_TICKS and VSYNC_LINES <= VBLANK_LINES < LINES.
- luma outside pix_rd ticks is ignored.

Decomposition:
- Package syncgen_pkg:
  - default timing constants for the 24 MHz build;
  - SYNC_LEVEL/BLANK_LEVEL/CVBS_MAX=63;
  - region enum {SYNC, BPORCH, ACTIVE, BLANK, BROAD}.
- Sub-module syncgen_timing: hcnt/vcnt counters plus region decode (region, pix_rd, wrap flags).
- The top level registers outputs and does the luma saturation.

Test Plan (small params: LINE_TICKS=64, HSYNC=5, BP=6, ACTIVE=48, LINES=10, VSYNC_LINES=2, VBLANK_LINES=3, ce=1):
- Normal line timing: release reset, run to vcnt=5 -> hsync low exactly 5 ticks, porch high 6 ticks, pix_rd high 48 ticks at hcnt 11..58, line period 64.
- Saturation: luma=60 -> cvbs=63; luma=0 -> 12; luma=51 -> 63; luma=50 -> 62.
- Frame structure: vcnt 0,1 -> vsync=0, cvbs=0 for 59 ticks then 12 for 5 ticks, porch=0; vcnt 2 -> normal sync and porch but pix_rd=0; frame_start every 640 ticks.
- ce gating: ce toggling 1/0 -> all periods double in clk cycles, outputs hold while ce=0, frame_start is 1 clk wide.
- Mid-line reset at vcnt=6, hcnt=30 -> outputs return immediately to cvbs=12/hsync=1/vsync=1/porch=0/pix_rd=0; after release, first sync tip appears on the first ce tick.
- Loopback into the sync detector with default params -> detector hsync period = 1536 ticks, one vsync per 312 lines, detector error never set.

Source files
------------

// File: rtl/syncgen_pkg.sv
// syncgen_pkg: shared constants and types for the composite sync generator.
//   - Default PAL-style timing for the 24 MHz sample clock.
//   - CVBS code levels and the saturation ceiling.
//   - Region enum and the decode struct passed from the timing core to the top.
package syncgen_pkg;

  localparam int DEF_LINE_TICKS      = 1536;  // 64 us
  localparam int DEF_HSYNC_TICKS     = 113;   // 4.7 us
  localparam int DEF_BACKPORCH_TICKS = 137;   // 5.7 us
  localparam int DEF_ACTIVE_TICKS    = 1248;
  localparam int DEF_LINES           = 312;
  localparam int DEF_VSYNC_LINES     = 3;
  localparam int DEF_VBLANK_LINES    = 25;
  localparam int DEF_SYNC_LEVEL      = 0;
  localparam int DEF_BLANK_LEVEL     = 12;

  localparam int CVBS_W = 6;
  localparam int LINE_W = 9;
  localparam logic [CVBS_W-1:0] CVBS_MAX = 6'd63;

  typedef enum logic [2:0] {SYNC, BPORCH, ACTIVE, BLANK, BROAD} region_e;

  // Decode of the current counter position.
  typedef struct packed {
    region_e region;
    logic    vs_line;  // broad-pulse line: vsync low for the whole line
    logic    pix_rd;   // luma is consumed on this tick
    logic    origin;   // hcnt == 0 and vcnt == 0
  } tdec_t;

  // Add in one extra bit and clamp at the top code. CVBS_MAX is the
  // all-ones code, so the carry alone says the sum overflowed.
  function automatic logic [CVBS_W-1:0] sat_add(input logic [CVBS_W-1:0] a,
                                                input logic [CVBS_W-1:0] b);
    logic [CVBS_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CVBS_W] ? CVBS_MAX : s[CVBS_W-1:0];
  endfunction

endpackage

// File: rtl/syncgen_timing.sv
// syncgen_timing: horizontal/vertical counters and region decode.
//   clk, reset : system clock, async active-high reset
//   ce         : sample-rate enable; counters advance only on ce
//   vcnt       : current line number
//   dec        : region, broad-line flag, pix_rd and frame-origin flag,
//                decoded combinationally from the counter registers
module syncgen_timing
  import syncgen_pkg::*;
#(
  parameter int LINE_TICKS      = DEF_LINE_TICKS,
  parameter int HSYNC_TICKS     = DEF_HSYNC_TICKS,
  parameter int BACKPORCH_TICKS = DEF_BACKPORCH_TICKS,
  parameter int ACTIVE_TICKS    = DEF_ACTIVE_TICKS,
  parameter int LINES           = DEF_LINES,
  parameter int VSYNC_LINES     = DEF_VSYNC_LINES,
  parameter int VBLANK_LINES    = DEF_VBLANK_LINES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  output logic [LINE_W-1:0] vcnt,
  output tdec_t             dec
);

  // One spare bit so the end of the active window can equal LINE_TICKS.
  localparam int HW = $clog2(LINE_TICKS + 1);

  localparam logic [HW-1:0] H_LAST      = HW'(LINE_TICKS - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(HSYNC_TICKS);
  localparam logic [HW-1:0] H_BP_END    = HW'(HSYNC_TICKS + BACKPORCH_TICKS);
  localparam logic [HW-1:0] H_ACT_END   = HW'(HSYNC_TICKS + BACKPORCH_TICKS + ACTIVE_TICKS);
  localparam logic [HW-1:0] H_BROAD_END = HW'(LINE_TICKS - HSYNC_TICKS);

  localparam logic [LINE_W-1:0] V_LAST   = LINE_W'(LINES - 1);
  localparam logic [LINE_W-1:0] V_VS_END = LINE_W'(VSYNC_LINES);
  localparam logic [LINE_W-1:0] V_VIS    = LINE_W'(VBLANK_LINES);

  if (HSYNC_TICKS + BACKPORCH_TICKS + ACTIVE_TICKS > LINE_TICKS) begin : g_bad_h
    $error("syncgen: sync + back porch + active exceeds LINE_TICKS");
  end
  if (VSYNC_LINES > VBLANK_LINES || VBLANK_LINES >= LINES) begin : g_bad_v
    $error("syncgen: need VSYNC_LINES <= VBLANK_LINES < LINES");
  end
  if (LINES > (1 << LINE_W)) begin : g_bad_w
    $error("syncgen: LINES does not fit the line output");
  end

  logic [HW-1:0] hcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  region_e rgn;
  logic    vs_line;

  always_comb begin
    vs_line = (vcnt < V_VS_END);
    rgn     = BLANK;
    if (vs_line) begin
      // Broad pulse: low for all but the last hsync-width of the line, so
      // a detector sees a low period far longer than a line sync.
      rgn = (hcnt < H_BROAD_END) ? BROAD : BLANK;
    end else if (hcnt < H_SYNC_END) begin
      rgn = SYNC;
    end else if (hcnt < H_BP_END) begin
      rgn = BPORCH;
    end else if (hcnt < H_ACT_END && vcnt >= V_VIS) begin
      rgn = ACTIVE;
    end
  end

  always_comb begin
    dec.region  = rgn;
    dec.vs_line = vs_line;
    dec.pix_rd  = (rgn == ACTIVE);
    dec.origin  = (hcnt == '0) && (vcnt == '0);
  end

endmodule

// File: rtl/syncgen.sv
// syncgen: composite video timing generator and sync inserter.
//   clk, reset  : system clock, async active-high reset
//   ce          : sample-rate enable
//   luma        : upstream pixel (0 = black), taken on ce ticks with pix_rd=1
//   cvbs        : registered 6-bit composite sample
//   hsync/vsync : registered active-low syncs
//   porch       : registered back-porch flag (normal lines only)
//   pix_rd      : luma consume strobe, decoded from the counters
//   frame_start : one-clk pulse with the output update of the frame origin
//   line        : current line counter
// Output registers capture the decode of the current position on each ce
// tick, so they trail the counters (and pix_rd / line) by one tick.
module syncgen
  import syncgen_pkg::*;
#(
  parameter int LINE_TICKS      = DEF_LINE_TICKS,
  parameter int HSYNC_TICKS     = DEF_HSYNC_TICKS,
  parameter int BACKPORCH_TICKS = DEF_BACKPORCH_TICKS,
  parameter int ACTIVE_TICKS    = DEF_ACTIVE_TICKS,
  parameter int LINES           = DEF_LINES,
  parameter int VSYNC_LINES     = DEF_VSYNC_LINES,
  parameter int VBLANK_LINES    = DEF_VBLANK_LINES,
  parameter int SYNC_LEVEL      = DEF_SYNC_LEVEL,
  parameter int BLANK_LEVEL     = DEF_BLANK_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [CVBS_W-1:0] luma,
  output logic [CVBS_W-1:0] cvbs,
  output logic              hsync,
  output logic              vsync,
  output logic              porch,
  output logic              pix_rd,
  output logic              frame_start,
  output logic [LINE_W-1:0] line
);

  localparam logic [CVBS_W-1:0] SYNC_LV  = CVBS_W'(SYNC_LEVEL);
  localparam logic [CVBS_W-1:0] BLANK_LV = CVBS_W'(BLANK_LEVEL);

  tdec_t             dec;
  logic [LINE_W-1:0] vcnt;

  syncgen_timing #(
    .LINE_TICKS      (LINE_TICKS),
    .HSYNC_TICKS     (HSYNC_TICKS),
    .BACKPORCH_TICKS (BACKPORCH_TICKS),
    .ACTIVE_TICKS    (ACTIVE_TICKS),
    .LINES           (LINES),
    .VSYNC_LINES     (VSYNC_LINES),
    .VBLANK_LINES    (VBLANK_LINES)
  ) u_timing (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .vcnt  (vcnt),
    .dec   (dec)
  );

  logic [CVBS_W-1:0] act_lvl;
  assign act_lvl = sat_add(BLANK_LV, luma);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cvbs        <= BLANK_LV;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      porch       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Not held by ce: the pulse lasts exactly one clk.
      frame_start <= ce & dec.origin;
      if (ce) begin
        hsync <= !(dec.region == SYNC || dec.region == BROAD);
        vsync <= !dec.vs_line;
        porch <= (dec.region == BPORCH);
        unique case (dec.region)
          SYNC, BROAD: cvbs <= SYNC_LV;
          ACTIVE:      cvbs <= act_lvl;
          default:     cvbs <= BLANK_LV;
        endcase
      end
    end
  end

  // Counters already sit at zero during reset; the gate just keeps the
  // strobe quiet for the whole reset pulse.
  assign pix_rd = dec.pix_rd & ~reset;
  assign line   = vcnt;

endmodule

// File: tb/tb_syncgen.sv
// tb_syncgen: small-parameter bench for syncgen. A position-based model
// (ce ticks since reset, folded into line/column) predicts every output and
// is compared each negedge; directed tasks pin literal timing values.
module tb_syncgen;
  localparam int L     = 64;
  localparam int HS    = 5;
  localparam int BP    = 6;
  localparam int ACT   = 48;
  localparam int NL    = 10;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int FRAME = L * NL;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce = 1'b0;
  logic [5:0] luma = '0;
  logic [5:0] cvbs;
  logic       hsync, vsync, porch, pix_rd, frame_start;
  logic [8:0] line;

  always #5 clk = ~clk;

  syncgen #(
    .LINE_TICKS(L), .HSYNC_TICKS(HS), .BACKPORCH_TICKS(BP), .ACTIVE_TICKS(ACT),
    .LINES(NL), .VSYNC_LINES(VS), .VBLANK_LINES(VB), .SYNC_LEVEL(0), .BLANK_LEVEL(12)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .luma(luma), .cvbs(cvbs), .hsync(hsync),
    .vsync(vsync), .porch(porch), .pix_rd(pix_rd), .frame_start(frame_start), .line(line)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs for position p (0..FRAME-1) straight from the line/frame rules.
  function automatic void expect_at(input int p, input int lu, output int cv,
                                    output bit hs, output bit vs, output bit po,
                                    output bit pr);
    int v, h;
    v = p / L; h = p % L;
    cv = 12; hs = 1; vs = 1; po = 0; pr = 0;
    if (v < VS) begin
      vs = 0;
      if (h < L - HS) begin cv = 0; hs = 0; end
    end else if (h < HS) begin
      cv = 0; hs = 0;
    end else if (h < HS + BP) begin
      po = 1;
    end else if (h < HS + BP + ACT && v >= VB) begin
      pr = 1;
      cv = (12 + lu > 63) ? 63 : 12 + lu;
    end
  endfunction

  // Model state: ce ticks since reset and the expected registered outputs.
  int unsigned ticks = 0;
  int  e_cvbs = 12;
  bit  e_hs = 1, e_vs = 1, e_po = 0, e_fs = 0, m_pr;
  bit  en_cmp = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ticks = 0; e_cvbs = 12; e_hs = 1; e_vs = 1; e_po = 0; e_fs = 0;
    end else begin
      e_fs = 0;
      if (ce) begin
        expect_at(int'(ticks % FRAME), int'(luma), e_cvbs, e_hs, e_vs, e_po, m_pr);
        e_fs = (ticks % FRAME == 0);
        ticks++;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int p, cv;
    bit h, v, po, pr;
    if (en_cmp) begin
      p = int'(ticks % FRAME);
      expect_at(p, 0, cv, h, v, po, pr);
      chk("cvbs", 32'(cvbs), 32'(e_cvbs));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("porch", 32'(porch), 32'(e_po));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("pix_rd", 32'(pix_rd), 32'(pr & !reset));
      chk("line", 32'(line), 32'(p / L));
    end
  end

  function automatic logic [5:0] pat(input int n);
    return 6'((n * 5) % 64);
  endfunction

  // Called at posedge+2; applies inputs, returns at the next posedge+2.
  task automatic tick(input bit c, input logic [5:0] l);
    ce = c; luma = l;
    @(posedge clk); #2;
  endtask

  task automatic run_to(input int v, input int h);
    int n = 0;
    while (int'(ticks % FRAME) != v * L + h) begin
      tick(1'b1, pat(n));
      n++;
      if (n > 2 * FRAME) begin
        checks++; failures++;
        $display("FAIL run_to timeout actual=%0d required=%0d", ticks % FRAME, v * L + h);
        break;
      end
    end
  endtask

  // Whole line at ce=1 from column 0: output counts and pix_rd span.
  task automatic measure_line(input int v, output int hl, output int po, output int pr,
                              output int pf, output int plast, output int c0, output int vl);
    run_to(v, 0);
    hl = 0; po = 0; pr = 0; pf = -1; plast = -1; c0 = 0; vl = 0;
    for (int h = 0; h < L; h++) begin
      if (pix_rd) begin pr++; if (pf < 0) pf = h; plast = h; end
      tick(1'b1, pat(h));
      if (!hsync) hl++;
      if (porch) po++;
      if (cvbs == 6'd0) c0++;
      if (!vsync) vl++;
    end
  endtask

  task automatic fs_period(input bit tog, output int period, output int wide);
    int first = -1;
    bit prev = 0;
    period = -1; wide = 0;
    for (int k = 0; k < 5 * FRAME; k++) begin
      tick(tog ? (k % 2 == 0) : 1'b1, pat(k));
      if (frame_start && prev) wide++;
      if (frame_start && !prev) begin
        if (first < 0) first = k;
        else begin period = k - first; break; end
      end
      prev = frame_start;
    end
  endtask

  task automatic sat(input logic [5:0] lu, input int exp);
    run_to(5, 20);
    tick(1'b1, lu);
    chk($sformatf("sat_luma%0d", lu), 32'(cvbs), 32'(exp));
  endtask

  int hl, po, pr, pf, plast, c0, vl, per, wide, e1, e2, low;
  bit prev_hs;

  initial begin
    reset = 1'b1;
    #1 en_cmp = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cvbs", 32'(cvbs), 12);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_porch", 32'(porch), 0);
    chk("rst_pix_rd", 32'(pix_rd), 0);
    chk("rst_fs", 32'(frame_start), 0);
    reset = 1'b0;

    tick(1'b1, 6'd0);
    chk("first_fs", 32'(frame_start), 1);
    chk("first_cvbs", 32'(cvbs), 0);
    chk("first_vsync", 32'(vsync), 0);
    tick(1'b1, 6'd0);
    chk("fs_one_clk", 32'(frame_start), 0);

    // Normal visible line.
    measure_line(5, hl, po, pr, pf, plast, c0, vl);
    chk("l5_hsync_low", hl, 5);
    chk("l5_porch", po, 6);
    chk("l5_pix_rd", pr, 48);
    chk("l5_pix_first", pf, 11);
    chk("l5_pix_last", plast, 58);
    chk("l5_cvbs_sync", c0, 5);
    chk("l5_vsync_low", vl, 0);

    // Broad-pulse line and blanked line.
    measure_line(0, hl, po, pr, pf, plast, c0, vl);
    chk("l0_hsync_low", hl, 59);
    chk("l0_cvbs_sync", c0, 59);
    chk("l0_porch", po, 0);
    chk("l0_vsync_low", vl, 64);
    chk("l0_pix_rd", pr, 0);
    measure_line(2, hl, po, pr, pf, plast, c0, vl);
    chk("l2_hsync_low", hl, 5);
    chk("l2_porch", po, 6);
    chk("l2_pix_rd", pr, 0);
    chk("l2_vsync_low", vl, 0);

    // Line period from consecutive hsync falls.
    run_to(7, 60);
    e1 = -1; e2 = -1; prev_hs = hsync;
    for (int k = 0; k < 200 && e2 < 0; k++) begin
      tick(1'b1, pat(k));
      if (prev_hs && !hsync) begin if (e1 < 0) e1 = k; else e2 = k; end
      prev_hs = hsync;
    end
    chk("line_period", e2 - e1, 64);

    // Saturation.
    sat(6'd60, 63);
    sat(6'd0, 12);
    sat(6'd51, 63);
    sat(6'd50, 62);

    // Frame period, ce continuous then toggling.
    fs_period(1'b0, per, wide);
    chk("fs_period_ce1", per, 640);
    chk("fs_wide_ce1", wide, 0);
    fs_period(1'b1, per, wide);
    chk("fs_period_tog", per, 1280);
    chk("fs_wide_tog", wide, 0);

    // Toggling ce doubles the hsync period and width in clks.
    run_to(4, 40);
    e1 = -1; e2 = -1; low = 0; prev_hs = hsync;
    for (int k = 0; k < 400 && e2 < 0; k++) begin
      tick(k % 2 == 0, pat(k));
      if (prev_hs && !hsync) begin if (e1 < 0) e1 = k; else e2 = k; end
      if (e1 >= 0 && e2 < 0 && !hsync) low++;
      prev_hs = hsync;
    end
    chk("tog_line_period", e2 - e1, 128);
    chk("tog_hsync_width", low, 10);

    // Mid-line reset inside the active window.
    run_to(6, 30);
    reset = 1'b1;
    #1;
    chk("mid_rst_cvbs", 32'(cvbs), 12);
    chk("mid_rst_hsync", 32'(hsync), 1);
    chk("mid_rst_vsync", 32'(vsync), 1);
    chk("mid_rst_porch", 32'(porch), 0);
    chk("mid_rst_pix_rd", 32'(pix_rd), 0);
    @(posedge clk); #2;
    tick(1'b1, 6'd40);
    tick(1'b1, 6'd40);
    reset = 1'b0;
    tick(1'b1, 6'd0);
    chk("post_rst_cvbs", 32'(cvbs), 0);
    chk("post_rst_hsync", 32'(hsync), 0);
    chk("post_rst_vsync", 32'(vsync), 0);
    chk("post_rst_fs", 32'(frame_start), 1);
    chk("post_rst_line", 32'(line), 0);
    repeat (4) tick(1'b1, 6'd0);

    @(negedge clk);
    en_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
